perceptron_trainer: RTL and testbench



---
 rtl/perceptron_pkg.sv | 21 ++
 rtl/weight_sat_update.sv | 20 ++
 rtl/perceptron_trainer.sv | 144 ++++++++++++++
 tb/tb_perceptron_trainer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared constants, weight type and trainer state encoding for the perceptron predictor.
package perceptron_pkg;

    localparam int unsigned GHR_WIDTH        = 16;
    localparam int unsigned WEIGHT_NUM       = GHR_WIDTH + 1;
    localparam int unsigned WEIGHT_ENTRY_NUM = 32;
    localparam int unsigned IDX_WIDTH        = $clog2(WEIGHT_ENTRY_NUM);
    localparam int          THETA            = 44;

    typedef logic signed [7:0] weight_t;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLoad,
        StUpdate,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/weight_sat_update.sv
// Saturating +/-1 step for one 8-bit signed perceptron weight.
module weight_sat_update
    import perceptron_pkg::*;
(
    input  weight_t weight,
    input  logic    inc,
    output weight_t new_weight
);

    // Step toward the requested direction, holding at +127 / -128.
    always_comb begin
        new_weight = weight;
        if (inc) begin
            if (weight != 8'sh7F) new_weight = weight + 8'sd1;
        end else begin
            if (weight != 8'sh80) new_weight = weight - 8'sd1;
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: on a resolved branch, read the entry's weight vector, apply the
// perceptron learning rule one weight per cycle, and write the vector back.
module perceptron_trainer #(
    parameter int unsigned GHR_WIDTH        = perceptron_pkg::GHR_WIDTH,
    parameter int unsigned WEIGHT_NUM       = GHR_WIDTH + 1,
    parameter int unsigned WEIGHT_ENTRY_NUM = perceptron_pkg::WEIGHT_ENTRY_NUM,
    parameter int unsigned IDX_WIDTH        = $clog2(WEIGHT_ENTRY_NUM),
    parameter int          THETA            = perceptron_pkg::THETA
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [IDX_WIDTH-1:0]    req_idx,
    input  logic [GHR_WIDTH-1:0]    req_ghr,
    input  logic                    req_outcome,
    input  logic signed [15:0]      req_sum,
    output logic                    wt_rd_en,
    output logic [IDX_WIDTH-1:0]    wt_rd_idx,
    input  logic [WEIGHT_NUM*8-1:0] wt_rd_data,
    output logic                    wt_wr_en,
    output logic [IDX_WIDTH-1:0]    wt_wr_idx,
    output logic [WEIGHT_NUM*8-1:0] wt_wr_data,
    output logic                    done,
    output logic                    trained
);

    import perceptron_pkg::*;

    // k runs one past the last weight; that extra UPDATE cycle fixes write-back latency.
    localparam int unsigned KW = $clog2(WEIGHT_NUM + 1);
    localparam logic [KW-1:0] KLast = KW'(WEIGHT_NUM);
    localparam logic signed [15:0] ThetaS = 16'(THETA);

    state_e                state_q, state_d;
    logic [KW-1:0]         k_q;
    weight_t               w_q [WEIGHT_NUM];
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [GHR_WIDTH-1:0]  ghr_q;
    logic                  outcome_q;
    logic                  trained_q;

    logic                  accept;
    logic                  in_margin;
    logic                  need_train;
    logic [WEIGHT_NUM-1:0] hist_ext;
    weight_t               cur_w;
    logic                  cur_h;
    logic                  inc;
    weight_t               new_w;

    assign accept     = req_valid && req_ready;
    assign in_margin  = (req_sum >= -ThetaS) && (req_sum <= ThetaS);
    // Predicted taken when sum >= 0, i.e. sign bit clear.
    assign need_train = (!req_sum[15] != req_outcome) || in_margin;

    // Bit 0 stands in for the bias input, which is always "taken".
    assign hist_ext = {ghr_q, 1'b1};
    assign inc      = (outcome_q == cur_h);

    // Select the weight and history bit addressed by k.
    always_comb begin
        cur_w = '0;
        cur_h = 1'b0;
        for (int unsigned i = 0; i < WEIGHT_NUM; i++) begin
            if (k_q == KW'(i)) begin
                cur_w = w_q[i];
                cur_h = hist_ext[i];
            end
        end
    end

    weight_sat_update u_sat (
        .weight     (cur_w),
        .inc        (inc),
        .new_weight (new_w)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = need_train ? StRead : StDone;
            StRead:   state_d = StLoad;
            StLoad:   state_d = StUpdate;
            StUpdate: if (k_q == KLast) state_d = StWrite;
            StWrite:  state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Request latch, working vector and weight counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            ghr_q     <= '0;
            outcome_q <= 1'b0;
            trained_q <= 1'b0;
            k_q       <= '0;
            for (int unsigned i = 0; i < WEIGHT_NUM; i++) w_q[i] <= '0;
        end else begin
            if (accept) begin
                idx_q     <= req_idx;
                ghr_q     <= req_ghr;
                outcome_q <= req_outcome;
                trained_q <= 1'b0;
            end
            if (state_q == StLoad) begin
                k_q <= '0;
                for (int unsigned i = 0; i < WEIGHT_NUM; i++) w_q[i] <= wt_rd_data[8*i +: 8];
            end
            if (state_q == StUpdate && k_q != KLast) begin
                k_q <= k_q + 1'b1;
                for (int unsigned i = 0; i < WEIGHT_NUM; i++) begin
                    if (k_q == KW'(i)) w_q[i] <= new_w;
                end
            end
            if (state_q == StWrite) trained_q <= 1'b1;
        end
    end

    // State-decoded outputs; everything idles at zero outside its own state.
    always_comb begin
        req_ready  = (state_q == StIdle);
        wt_rd_en   = (state_q == StRead);
        wt_wr_en   = (state_q == StWrite);
        done       = (state_q == StDone);
        trained    = done && trained_q;
        wt_rd_idx  = wt_rd_en ? idx_q : '0;
        wt_wr_idx  = wt_wr_en ? idx_q : '0;
        wt_wr_data = '0;
        if (wt_wr_en) begin
            for (int unsigned i = 0; i < WEIGHT_NUM; i++) wt_wr_data[8*i +: 8] = w_q[i];
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer with a behavioural weight table.
module tb_perceptron_trainer;

    localparam int unsigned WN = 17;
    localparam int unsigned DW = WN * 8;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_idx;
    logic [15:0]   req_ghr;
    logic          req_outcome;
    logic signed [15:0] req_sum;
    logic          wt_rd_en;
    logic [4:0]    wt_rd_idx;
    logic [DW-1:0] wt_rd_data;
    logic          wt_wr_en;
    logic [4:0]    wt_wr_idx;
    logic [DW-1:0] wt_wr_data;
    logic          done;
    logic          trained;

    perceptron_trainer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_idx     (req_idx),
        .req_ghr     (req_ghr),
        .req_outcome (req_outcome),
        .req_sum     (req_sum),
        .wt_rd_en    (wt_rd_en),
        .wt_rd_idx   (wt_rd_idx),
        .wt_rd_data  (wt_rd_data),
        .wt_wr_en    (wt_wr_en),
        .wt_wr_idx   (wt_wr_idx),
        .wt_wr_data  (wt_wr_data),
        .done        (done),
        .trained     (trained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight table: read data appears the cycle after the strobe.
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (wt_rd_en) wt_rd_data <= mem[wt_rd_idx];
        if (wt_wr_en) mem[wt_wr_idx] = wt_wr_data;
    end

    int            checks = 0;
    int            errors = 0;
    int            acc_n, rd_count, wr_count, done_count;
    int            rd_cyc, wr_cyc, done_cyc;
    int            acc_edge [4];
    logic [4:0]    rd_idx_seen, wr_idx_seen;
    logic [DW-1:0] wr_data_seen;
    logic          trained_seen, ready_at_done;

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (req_valid && req_ready) begin
            if (acc_n < 4) acc_edge[acc_n] = cyc + 1;
            acc_n++;
        end
        if (wt_rd_en) begin
            rd_count++;
            rd_cyc      = cyc;
            rd_idx_seen = wt_rd_idx;
        end
        if (wt_wr_en) begin
            wr_count++;
            wr_cyc       = cyc;
            wr_idx_seen  = wt_wr_idx;
            wr_data_seen = wt_wr_data;
        end
        if (done) begin
            done_count++;
            done_cyc      = cyc;
            trained_seen  = trained;
            ready_at_done = req_ready;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        acc_n = 0; rd_count = 0; wr_count = 0; done_count = 0;
        rd_cyc = -1; wr_cyc = -1; done_cyc = -1;
        trained_seen = 1'bx; ready_at_done = 1'bx;
    endtask

    // Present one request and return the acceptance edge number.
    task automatic start_req(input logic [4:0] idx, input logic [15:0] ghr, input logic outc,
                             input int sum, output int n);
        @(posedge clk); #1;
        chk("ready_before_req", DW'(req_ready), DW'(1));
        clear_mon();
        req_idx = idx; req_ghr = ghr; req_outcome = outc; req_sum = 16'(sum);
        req_valid = 1'b1;
        @(posedge clk); #1;
        n = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int want, input int budget);
        for (int i = 0; i < budget && done_count < want; i++) begin
            @(posedge clk); #1;
        end
        chki("done_within_budget", int'(done_count >= want), 1);
    endtask

    task automatic run_train(input string tag, input logic [4:0] idx, input logic [15:0] ghr,
                             input logic outc, input int sum, input logic [DW-1:0] exp_data);
        int n;
        start_req(idx, ghr, outc, sum, n);
        wait_done(1, 40);
        chki({tag, "_wr_count"}, wr_count, 1);
        chk({tag, "_wr_idx"}, DW'(wr_idx_seen), DW'(idx));
        chk({tag, "_wr_data"}, wr_data_seen, exp_data);
        chk({tag, "_trained"}, DW'(trained_seen), DW'(1));
    endtask

    task automatic run_notrain(input string tag, input logic outc, input int sum);
        int n;
        start_req(5'd20, 16'h0, outc, sum, n);
        wait_done(1, 10);
        chki({tag, "_done_lat"}, done_cyc - n + 1, 1);
        chk({tag, "_trained"}, DW'(trained_seen), DW'(0));
        chki({tag, "_rd_count"}, rd_count, 0);
        chki({tag, "_wr_count"}, wr_count, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[7]  = {WN{8'h7F}};
        mem[8]  = {WN{8'h80}};
        mem[12] = {WN{8'h80}};
        clear_mon();
        rst_n = 1'b0; req_valid = 1'b0; req_idx = '0; req_ghr = '0;
        req_outcome = 1'b0; req_sum = '0;

        // Reset values.
        #2;
        chk("rst_ready", DW'(req_ready), DW'(1));
        chk("rst_rd_en", DW'(wt_rd_en), DW'(0));
        chk("rst_wr_en", DW'(wt_wr_en), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_trained", DW'(trained), DW'(0));
        chk("rst_rd_idx", DW'(wt_rd_idx), DW'(0));
        chk("rst_wr_idx", DW'(wt_wr_idx), DW'(0));
        chk("rst_wr_data", wt_wr_data, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Mispredicted branch, zero weights, all-taken history: full-latency training.
        start_req(5'd3, 16'hFFFF, 1'b1, -5, n);
        wait_done(1, 40);
        chki("a_rd_lat", rd_cyc - n + 1, 1);
        chk("a_rd_idx", DW'(rd_idx_seen), DW'(3));
        chki("a_wr_lat", wr_cyc - n + 1, 21);
        chk("a_wr_idx", DW'(wr_idx_seen), DW'(3));
        chk("a_wr_data", wr_data_seen, {WN{8'h01}});
        chki("a_done_lat", done_cyc - n + 1, 22);
        chk("a_trained", DW'(trained_seen), DW'(1));
        chki("a_counts", rd_count * 10 + wr_count, 11);
        chk("a_ready_at_done", DW'(ready_at_done), DW'(0));

        // Confident correct prediction: straight to DONE, ready again the cycle after.
        run_notrain("b", 1'b1, 100);
        chk("b_ready_after", DW'(req_ready), DW'(1));

        // Threshold edges: +44 trains, +45 and -45 do not.
        run_train("c44", 5'd5, 16'h0000, 1'b1, 44, {{16{8'hFF}}, 8'h01});
        run_notrain("c45", 1'b1, 45);
        run_notrain("cm45", 1'b0, -45);

        // Saturation at both rails, plus the mixed-direction case at the negative rail.
        run_train("d_hi", 5'd7, 16'hFFFF, 1'b1, 0, {WN{8'h7F}});
        run_train("d_lo", 5'd8, 16'hFFFF, 1'b0, 0, {WN{8'h80}});
        run_train("d_mix", 5'd12, 16'h0000, 1'b0, 0, {{16{8'h81}}, 8'h80});

        // Reset in the middle of UPDATE aborts with no write.
        start_req(5'd9, 16'hFFFF, 1'b1, -5, n);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("r_ready_in_rst", DW'(req_ready), DW'(1));
        chk("r_wr_en_in_rst", DW'(wt_wr_en), DW'(0));
        chk("r_done_in_rst", DW'(done), DW'(0));
        @(posedge clk); #1;
        chk("r_ready_in_rst2", DW'(req_ready), DW'(1));
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chki("r_no_write", wr_count, 0);
        chki("r_no_done", done_count, 0);
        chk("r_mem_untouched", mem[9], '0);
        run_train("r_next", 5'd10, 16'hFFFF, 1'b1, -5, {WN{8'h01}});

        // req_valid held high: one extra acceptance, on the edge after DONE.
        @(posedge clk); #1;
        clear_mon();
        req_idx = 5'd11; req_ghr = 16'hFFFF; req_outcome = 1'b1; req_sum = -16'sd5;
        req_valid = 1'b1;
        for (int i = 0; i < 80 && acc_n < 2; i++) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        wait_done(2, 40);
        repeat (5) @(posedge clk);
        #1;
        chki("h_acc_count", acc_n, 2);
        chki("h_acc_gap", acc_edge[1] - acc_edge[0], 23);
        chki("h_wr_count", wr_count, 2);
        chk("h_wr_data", wr_data_seen, {WN{8'h02}});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if something stalls the directed sequence.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "timeout");
    end

endmodule
